// File: rtl/edge_pulse_ctrl_if.sv
// Signal bundle for edge_pulse_ctrl: raw inputs, modes and clears in, pulses and sticky flags out.
// The master side drives the stimulus and the slave side is the pulse generator.
interface edge_pulse_ctrl_if #(
  parameter int NUM = 1
);
  logic [NUM-1:0]   sig_I;
  logic [2*NUM-1:0] mode_I;
  logic [NUM-1:0]   clr_I;
  logic [NUM-1:0]   pulse_O;
  logic [NUM-1:0]   event_O;

  modport master (
    output sig_I, mode_I, clr_I,
    input  pulse_O, event_O
  );

  modport slave (
    input  sig_I, mode_I, clr_I,
    output pulse_O, event_O
  );
endinterface

// File: rtl/edge_pulse_ctrl.sv
// Multi-channel edge-to-pulse generator: synchronise, optionally debounce (EDGE_PULSE_DEBOUNCE_EN),
// detect the selected edge, stretch it to PULSE_LEN cycles and keep a sticky, software-cleared event flag.
module edge_pulse_ctrl #(
  parameter int NUM         = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int PULSE_LEN   = 1,
  parameter int DB_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  edge_pulse_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(PULSE_LEN - 1);

  // Out-of-range parameters leave this empty scope in the elaborated hierarchy as a marker.
  if (PULSE_LEN < 1 || SYNC_STAGES < 1 || DB_CYCLES < 1) begin : g_param_out_of_range
  end

  for (genvar gi = 0; gi < NUM; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_stab;
    logic                   r_prev;
    logic [1:0]             w_mode;
    logic                   w_det;
    logic                   r_det;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pulse;
    logic                   r_event;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= bus.sig_I[gi];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          r_sync[k] <= r_sync[k-1];
        end
      end
    end

`ifdef EDGE_PULSE_DEBOUNCE_EN
    logic             r_stab;
    logic [CNT_W-1:0] r_dbc;

    // stab only follows sync after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_stab <= 1'b0;
        r_dbc  <= '0;
      end else if (r_sync[SYNC_STAGES-1] == r_stab) begin
        r_dbc  <= '0;
      end else if (r_dbc == CNT_W'(DB_CYCLES - 1)) begin
        r_stab <= r_sync[SYNC_STAGES-1];
        r_dbc  <= '0;
      end else begin
        r_dbc  <= r_dbc + 1'b1;
      end
    end

    assign w_stab = r_stab;
`else
    assign w_stab = r_sync[SYNC_STAGES-1];
`endif

    assign w_mode = bus.mode_I[2*gi +: 2];

    always_comb begin
      w_det = 1'b0;
      case (w_mode)
        2'b01:   w_det = w_stab & ~r_prev;
        2'b10:   w_det = ~w_stab & r_prev;
        2'b11:   w_det = w_stab ^ r_prev;
        default: w_det = 1'b0;
      endcase
    end

    // Detection is registered once before the stretcher, giving SYNC_STAGES+1 edges of input-to-pulse latency.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_prev  <= 1'b0;
        r_det   <= 1'b0;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_event <= 1'b0;
      end else begin
        r_prev <= w_stab;
        r_det  <= w_det;

        if (r_det) begin
          r_cnt   <= LP_RELOAD;
          r_pulse <= 1'b1;
        end else if (r_cnt != '0) begin
          r_cnt   <= r_cnt - 1'b1;
          r_pulse <= 1'b1;
        end else begin
          r_pulse <= 1'b0;
        end

        // A detection in the same cycle as a clear wins, so no event is lost.
        if (r_det) begin
          r_event <= 1'b1;
        end else if (bus.clr_I[gi]) begin
          r_event <= 1'b0;
        end
      end
    end

    assign bus.pulse_O[gi] = r_pulse;
    assign bus.event_O[gi] = r_event;
  end

endmodule

// File: tb/tb_edge_pulse_ctrl.sv
// Self-checking bench for edge_pulse_ctrl: vector table, multi-cycle corner sequences and a randomized
// run against a reference model ("pulse high iff a detection happened in the last PULSE_LEN cycles").
module tb_edge_pulse_ctrl;
  localparam int NUM   = 4;
  localparam int SS    = 2;
  localparam int CNT_W = 8;
  localparam int PL    = 3;
  localparam int DB    = 4;
  localparam int NRAND = 300;

  typedef struct packed {
    logic [NUM-1:0]   sig;
    logic [2*NUM-1:0] mode;
    logic [NUM-1:0]   clr;
    logic [NUM-1:0]   pulse;
    logic [NUM-1:0]   evt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = 0;

  logic [NUM-1:0]   s_hist [0:NRAND];
  logic [2*NUM-1:0] m_hist [0:NRAND];
  logic [NUM-1:0]   c_hist [0:NRAND];
  logic [NUM-1:0]   d_hist [0:NRAND];

  always #5 clk = ~clk;

  edge_pulse_ctrl_if #(.NUM(NUM)) bus ();

  edge_pulse_ctrl #(
    .NUM(NUM), .SYNC_STAGES(SS), .CNT_W(CNT_W), .PULSE_LEN(PL), .DB_CYCLES(DB)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
    end
  endtask

  // Drive inputs in the low phase, then sample outputs 1 time unit after the next rising edge.
  task automatic step(input logic [NUM-1:0] s, input logic [2*NUM-1:0] m, input logic [NUM-1:0] c);
    bus.sig_I  = s;
    bus.mode_I = m;
    bus.clr_I  = c;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset(input logic [NUM-1:0] s, input logic [2*NUM-1:0] m);
    bus.sig_I  = s;
    bus.mode_I = m;
    bus.clr_I  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    edge_n = 0;
  endtask

  task automatic run_seq(input int nsteps, input int ch, input int on_from, input int on_to,
                         input logic [2*NUM-1:0] m, output int first_rise, output int last_rise,
                         output int rises, output int highs);
    logic prev_p;
    prev_p     = 1'b0;
    first_rise = -1;
    last_rise  = -1;
    rises      = 0;
    highs      = 0;
    for (int k = 1; k <= nsteps; k++) begin
      logic [NUM-1:0] s;
      s = '0;
      if (k >= on_from && k <= on_to) s[ch] = 1'b1;
      step(s, m, '0);
      if (bus.pulse_O[ch]) begin
        highs++;
        if (!prev_p) begin
          rises++;
          if (first_rise < 0) first_rise = edge_n;
          last_rise = edge_n;
        end
      end
      prev_p = bus.pulse_O[ch];
    end
  endtask

  initial begin
    int fr, lr, rs, hs;
    bus.sig_I  = '0;
    bus.mode_I = '0;
    bus.clr_I  = '0;
    do_reset('0, '0);
    check("reset_pulse", 32'(bus.pulse_O), 32'h0);
    check("reset_event", 32'(bus.event_O), 32'h0);

`ifndef EDGE_PULSE_DEBOUNCE_EN
    begin : table_test
      vec_t tbl [15];
      // ch0/1/3 posedge, ch2 negedge; ch0 and ch2 rise at edge 1 and fall at edge 9.
      tbl[ 0] = '{sig:4'h5, mode:8'h65, clr:4'h0, pulse:4'h0, evt:4'h0};
      tbl[ 1] = '{sig:4'h5, mode:8'h65, clr:4'h0, pulse:4'h0, evt:4'h0};
      tbl[ 2] = '{sig:4'h5, mode:8'h65, clr:4'h0, pulse:4'h0, evt:4'h0};
      tbl[ 3] = '{sig:4'h5, mode:8'h65, clr:4'h0, pulse:4'h1, evt:4'h1};
      tbl[ 4] = '{sig:4'h5, mode:8'h65, clr:4'h0, pulse:4'h1, evt:4'h1};
      tbl[ 5] = '{sig:4'h5, mode:8'h65, clr:4'h0, pulse:4'h1, evt:4'h1};
      tbl[ 6] = '{sig:4'h5, mode:8'h65, clr:4'h0, pulse:4'h0, evt:4'h1};
      tbl[ 7] = '{sig:4'h5, mode:8'h65, clr:4'h1, pulse:4'h0, evt:4'h0};
      tbl[ 8] = '{sig:4'h0, mode:8'h65, clr:4'h0, pulse:4'h0, evt:4'h0};
      tbl[ 9] = '{sig:4'h0, mode:8'h65, clr:4'h0, pulse:4'h0, evt:4'h0};
      tbl[10] = '{sig:4'h0, mode:8'h65, clr:4'h0, pulse:4'h0, evt:4'h0};
      tbl[11] = '{sig:4'h0, mode:8'h65, clr:4'h0, pulse:4'h4, evt:4'h4};
      tbl[12] = '{sig:4'h0, mode:8'h65, clr:4'h0, pulse:4'h4, evt:4'h4};
      tbl[13] = '{sig:4'h0, mode:8'h65, clr:4'h0, pulse:4'h4, evt:4'h4};
      tbl[14] = '{sig:4'h0, mode:8'h65, clr:4'h0, pulse:4'h0, evt:4'h4};
      for (int i = 0; i < 15; i++) begin
        step(tbl[i].sig, tbl[i].mode, tbl[i].clr);
        $display("[TB] vec %0d sig=%h mode=%h clr=%h -> pulse=%h event=%h",
                 i, tbl[i].sig, tbl[i].mode, tbl[i].clr, bus.pulse_O, bus.event_O);
        check($sformatf("tbl%0d_pulse", i), 32'(bus.pulse_O), 32'(tbl[i].pulse));
        check($sformatf("tbl%0d_event", i), 32'(bus.event_O), 32'(tbl[i].evt));
      end
    end

    // Toggle mode, edges 10 cycles apart: two separate PL-cycle pulses.
    do_reset('0, 8'h0C);
    run_seq(22, 1, 1, 10, 8'h0C, fr, lr, rs, hs);
    $display("[TB] toggle_sep first=%0d last=%0d rises=%0d highs=%0d", fr, lr, rs, hs);
    check("toggle_sep_first", 32'(fr), 32'd4);
    check("toggle_sep_last",  32'(lr), 32'd14);
    check("toggle_sep_rises", 32'(rs), 32'd2);
    check("toggle_sep_highs", 32'(hs), 32'(2*PL));

    // Toggle mode, edges 2 cycles apart: one continuous pulse of 2+PL cycles.
    do_reset('0, 8'h0C);
    run_seq(12, 1, 1, 2, 8'h0C, fr, lr, rs, hs);
    $display("[TB] retrigger first=%0d rises=%0d highs=%0d", fr, rs, hs);
    check("retrig_first", 32'(fr), 32'd4);
    check("retrig_rises", 32'(rs), 32'd1);
    check("retrig_highs", 32'(hs), 32'(2 + PL));

    // Detection and clear in the same cycle: set wins; a lone clear then drops the flag.
    do_reset('0, 8'h01);
    repeat (3) step(4'h1, 8'h01, 4'h0);
    check("clr_pre_event", 32'(bus.event_O), 32'h0);
    step(4'h1, 8'h01, 4'h1);
    check("clr_same_cycle_event", 32'(bus.event_O), 32'h1);
    check("clr_same_cycle_pulse", 32'(bus.pulse_O), 32'h1);
    step(4'h1, 8'h01, 4'h1);
    check("clr_alone_event", 32'(bus.event_O), 32'h0);
    step(4'h1, 8'h01, 4'h0);
    check("clr_stays_event", 32'(bus.event_O), 32'h0);
    $display("[TB] clear sequence done, event=%h", bus.event_O);

    // Reset mid-pulse, then inputs already high at release report a posedge.
    do_reset(4'hF, 8'h55);
    repeat (4) step(4'hF, 8'h55, 4'h0);
    check("rst_pre_pulse", 32'(bus.pulse_O), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_pulse", 32'(bus.pulse_O), 32'h0);
    check("rst_async_event", 32'(bus.event_O), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    edge_n = 0;
    for (int k = 1; k <= 4; k++) begin
      step(4'hF, 8'h55, 4'h0);
      check($sformatf("rst_release_pulse%0d", k), 32'(bus.pulse_O), (k == 4) ? 32'hF : 32'h0);
    end
    $display("[TB] reset sequence done, pulse=%h event=%h", bus.pulse_O, bus.event_O);

    // Randomized run against the reference model.
    begin : random_test
      logic [NUM-1:0]   cur_s;
      logic [2*NUM-1:0] cur_m;
      logic [NUM-1:0]   cur_c;
      logic [NUM-1:0]   ev_m;
      logic [NUM-1:0]   p_m;
      int               rand_fail_start;
      do_reset('0, '0);
      s_hist[0] = '0;
      m_hist[0] = '0;
      c_hist[0] = '0;
      d_hist[0] = '0;
      cur_s = '0;
      cur_m = '0;
      ev_m  = '0;
      rand_fail_start = n_fail;
      for (int n = 1; n <= NRAND; n++) begin
        if (n % 16 == 1) cur_m = (2*NUM)'($urandom);
        for (int ch = 0; ch < NUM; ch++) begin
          if ($urandom_range(3) == 0) cur_s[ch] = ~cur_s[ch];
          cur_c[ch] = ($urandom_range(7) == 0);
        end
        s_hist[n] = cur_s;
        m_hist[n] = cur_m;
        c_hist[n] = cur_c;
        step(cur_s, cur_m, cur_c);
        for (int ch = 0; ch < NUM; ch++) begin
          logic a, b, d;
          // Detection seen by the stretcher at edge n compares the input sampled SS and SS+1 edges earlier.
          a = (n - SS >= 1)     ? s_hist[n-SS][ch]   : 1'b0;
          b = (n - SS - 1 >= 1) ? s_hist[n-SS-1][ch] : 1'b0;
          case (m_hist[n][2*ch +: 2])
            2'b01:   d = a & ~b;
            2'b10:   d = ~a & b;
            2'b11:   d = a ^ b;
            default: d = 1'b0;
          endcase
          d_hist[n][ch] = d;
          p_m[ch] = 1'b0;
          for (int k = n - PL; k <= n - 1; k++) begin
            if (k >= 1 && d_hist[k][ch]) p_m[ch] = 1'b1;
          end
          ev_m[ch] = d_hist[n-1][ch] | (ev_m[ch] & ~c_hist[n][ch]);
        end
        check("rand_pulse", 32'(bus.pulse_O), 32'(p_m));
        check("rand_event", 32'(bus.event_O), 32'(ev_m));
      end
      $display("[TB] random run: %0d cycles, %0d mismatching checks", NRAND, n_fail - rand_fail_start);
    end
`else
    // Short glitch is rejected by the debouncer.
    do_reset('0, 8'h01);
    run_seq(16, 0, 1, 3, 8'h01, fr, lr, rs, hs);
    $display("[TB] glitch rises=%0d highs=%0d event=%h", rs, hs, bus.event_O);
    check("db_glitch_rises", 32'(rs), 32'd0);
    check("db_glitch_highs", 32'(hs), 32'd0);
    check("db_glitch_event", 32'(bus.event_O), 32'h0);

    // Long-enough high passes, DB cycles later than without debouncing.
    do_reset('0, 8'h01);
    run_seq(16, 0, 1, 6, 8'h01, fr, lr, rs, hs);
    $display("[TB] debounced first=%0d rises=%0d highs=%0d event=%h", fr, rs, hs, bus.event_O);
    check("db_pass_first", 32'(fr), 32'(4 + DB));
    check("db_pass_rises", 32'(rs), 32'd1);
    check("db_pass_highs", 32'(hs), 32'(PL));
    check("db_pass_event", 32'(bus.event_O), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
